// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with a one-deep output register plus skid buffer.
// Optional CSR-immediate decode is enabled by defining IMM_GEN_CSR_EN.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit SHAMT_SPLIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_CSR_EN
    localparam logic [2:0] FMT_CSR   = 3'd7;
`endif

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } res_t;

    // Widen a 32-bit signed value to XLEN without a zero-width replication at XLEN=32.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            use_target;
    res_t            dec_next;
    res_t            o_reg;
    res_t            k_reg;
    logic            o_valid_reg;
    logic            k_valid_reg;
    logic            accept;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    always_comb begin
        dec_next   = '0;
        use_target = 1'b0;
        case (opcode)
            7'b0000011, 7'b0001111, 7'b1100111: begin
                dec_next.fmt = FMT_I;
                dec_next.imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
            end
            7'b0010011: begin
                if (SHAMT_SPLIT && (funct3 == 3'b001 || funct3 == 3'b101)) begin
                    dec_next.fmt = FMT_SHAMT;
                    if (XLEN == 32)
                        dec_next.imm[4:0] = in_inst[24:20];
                    else
                        dec_next.imm[5:0] = in_inst[25:20];
                end else begin
                    dec_next.fmt = FMT_I;
                    dec_next.imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
                end
            end
            7'b0100011: begin
                dec_next.fmt = FMT_S;
                dec_next.imm = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
            end
            7'b1100011: begin
                dec_next.fmt = FMT_B;
                dec_next.imm = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                       in_inst[30:25], in_inst[11:8], 1'b0});
                use_target   = 1'b1;
            end
            7'b1101111: begin
                dec_next.fmt = FMT_J;
                dec_next.imm = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                       in_inst[20], in_inst[30:21], 1'b0});
                use_target   = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec_next.fmt = FMT_U;
                dec_next.imm = sext32({in_inst[31:12], 12'b0});
                use_target   = opcode[5] == 1'b0;  // AUIPC only
            end
            7'b0110011: begin
                dec_next.fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
                if (funct3[2]) begin
                    dec_next.fmt      = FMT_CSR;
                    dec_next.imm[4:0] = in_inst[19:15];
                end else if (funct3 != 3'b000) begin
                    dec_next.fmt       = FMT_I;
                    dec_next.imm[11:0] = in_inst[31:20];
                end
`else
                dec_next.fmt = FMT_NONE;
`endif
            end
            default: begin
                dec_next.illegal = 1'b1;
            end
        endcase
        dec_next.target = use_target ? (in_pc + dec_next.imm) : '0;
    end

    assign in_ready = !k_valid_reg && !reset;
    assign accept   = in_valid && in_ready;

    // O refills from K first so ordering stays FIFO; K only loads while O is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_reg       <= '0;
            k_reg       <= '0;
            o_valid_reg <= 1'b0;
            k_valid_reg <= 1'b0;
        end else if (!o_valid_reg || out_ready) begin
            if (k_valid_reg) begin
                o_reg       <= k_reg;
                o_valid_reg <= 1'b1;
                k_valid_reg <= 1'b0;
            end else if (accept) begin
                o_reg       <= dec_next;
                o_valid_reg <= 1'b1;
            end else begin
                o_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            k_reg       <= dec_next;
            k_valid_reg <= 1'b1;
        end
    end

    assign out_valid   = o_valid_reg;
    assign out_imm     = o_reg.imm;
    assign out_fmt     = o_reg.fmt;
    assign out_target  = o_reg.target;
    assign out_illegal = o_reg.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32/SHAMT_SPLIT=1 and XLEN=64/SHAMT_SPLIT=0 instances.
// CSR expectations follow IMM_GEN_CSR_EN when it is defined for the build.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_target;
    logic        out_illegal;

    logic [63:0] in_pc64;
    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [63:0] out_target64;
    logic        out_illegal64;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] seen_q[$];

    assign in_pc64 = {32'h0, in_pc};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SHAMT_SPLIT(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .SHAMT_SPLIT(1'b0)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64),
        .out_illegal(out_illegal64)
    );

    // Record every completed output handshake of the 32-bit instance.
    always @(posedge clk) begin
        if (out_valid && out_ready)
            seen_q.push_back(out_target);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("sent inst=%h pc=%h -> valid=%b imm=%h fmt=%0d target=%h illegal=%b",
                 inst, pc, out_valid, out_imm, out_fmt, out_target, out_illegal);
    endtask

    initial begin
        int n0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_fmt", out_fmt, 0);
        chk("rst_out_target", out_target, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // BEQ with negative offset
        send(32'hFE000EE3, 32'h100);
        chk("beq_valid", out_valid, 1);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_fmt", out_fmt, 3);
        chk("beq_target", out_target, 32'h000000FC);
        chk("beq64_imm", out_imm64, 64'hFFFFFFFFFFFFFFFC);
        chk("beq64_target", out_target64, 64'h00000000000000FC);

        // LUI
        send(32'h800000B7, 32'h200);
        chk("lui_imm", out_imm, 32'h80000000);
        chk("lui_fmt", out_fmt, 4);
        chk("lui_target", out_target, 0);
        chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", out_fmt64, 4);
        chk("lui64_target", out_target64, 0);

        // SRAI
        send(32'h4030D093, 32'h300);
        chk("srai_fmt", out_fmt, 6);
        chk("srai_imm", out_imm, 3);
        chk("srai64_fmt", out_fmt64, 1);
        chk("srai64_imm", out_imm64, 64'h403);

        // AUIPC with wrap-around of pc + imm
        send(32'hFFFFF097, 32'h2000);
        chk("auipc_imm", out_imm, 32'hFFFFF000);
        chk("auipc_fmt", out_fmt, 4);
        chk("auipc_target", out_target, 32'h00001000);
        chk("auipc64_target", out_target64, 64'h0000000000001000);

        // SW x1,-4(x2)
        send(32'hFE112E23, 32'h400);
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_fmt", out_fmt, 2);
        chk("sw_target", out_target, 0);

        // JALR x1,16(x1): target not computable here
        send(32'h010080E7, 32'h400);
        chk("jalr_imm", out_imm, 32'h10);
        chk("jalr_fmt", out_fmt, 1);
        chk("jalr_target", out_target, 0);

        // JAL x0,-8
        send(32'hFF9FF06F, 32'h500);
        chk("jal_neg_imm", out_imm, 32'hFFFFFFF8);
        chk("jal_neg_fmt", out_fmt, 5);
        chk("jal_neg_target", out_target, 32'h4F8);

        // ADD: legal, no immediate
        send(32'h002081B3, 32'h600);
        chk("add_fmt", out_fmt, 0);
        chk("add_imm", out_imm, 0);
        chk("add_illegal", out_illegal, 0);

        // All-zero word is illegal
        send(32'h00000000, 32'h700);
        chk("ill_illegal", out_illegal, 1);
        chk("ill_imm", out_imm, 0);
        chk("ill_fmt", out_fmt, 0);

        // CSRRWI
        send(32'h3002D073, 32'h800);
`ifdef IMM_GEN_CSR_EN
        chk("csrrwi_fmt", out_fmt, 7);
        chk("csrrwi_imm", out_imm, 5);
`else
        chk("csrrwi_fmt", out_fmt, 0);
        chk("csrrwi_imm", out_imm, 0);
`endif
        chk("csrrwi_illegal", out_illegal, 0);

        @(posedge clk); #1;
        chk("idle_out_valid", out_valid, 0);

        // Stall: four JAL x0,8 back to back, out_ready low for three cycles
        n0        = seen_q.size();
        out_ready = 1'b0;
        in_inst   = 32'h0080006F;
        in_pc     = 32'h10;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("stall_in_ready_after_1st", in_ready, 1);
        chk("stall_first_target", out_target, 32'h18);
        in_pc = 32'h20;
        @(posedge clk); #1;
        $display("stall cycle: in_ready=%b out_target=%h", in_ready, out_target);
        chk("stall_in_ready_drop", in_ready, 0);
        chk("stall_hold_target_a", out_target, 32'h18);
        in_pc = 32'h30;
        @(posedge clk); #1;
        chk("stall_hold_target_b", out_target, 32'h18);
        chk("stall_hold_imm", out_imm, 32'h8);
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_skid_target", out_target, 32'h28);
        chk("drain_in_ready_rise", in_ready, 1);
        @(posedge clk); #1;
        chk("drain_third_target", out_target, 32'h38);
        in_pc = 32'h40;
        @(posedge clk); #1;
        chk("drain_fourth_target", out_target, 32'h48);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_empty", out_valid, 0);
        chk("stall_count", seen_q.size() - n0, 4);
        if (seen_q.size() - n0 == 4) begin
            chk("order_0", seen_q[n0],     32'h18);
            chk("order_1", seen_q[n0 + 1], 32'h28);
            chk("order_2", seen_q[n0 + 2], 32'h38);
            chk("order_3", seen_q[n0 + 3], 32'h48);
        end

        // Reset with O and K both full
        out_ready = 1'b0;
        send(32'h0080006F, 32'h100);
        send(32'h0080006F, 32'h200);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        n0    = seen_q.size();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_target", out_target, 0);
        chk("midrst_in_ready", in_ready, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_no_output", out_valid, 0);
        chk("postrst_no_handshake", seen_q.size() - n0, 0);
        chk("postrst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
